spi_flash_responder: RTL and testbench

//  SPI mode-0 target that emulates the command layer of a serial NOR flash on the far end of
//  the spictl master link. Oversamples spi_clk/spi_cs/spi_di in the sclk domain, decodes opcodes,

---
 rtl/spi_flash_responder.sv | 261 ++++++++++++++++++++++++++
 tb/tb_spi_flash_responder.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/spi_flash_responder.sv
//==============================================================================
// Module      : spi_flash_responder
// Description : SPI mode-0 target emulating the command layer of a serial NOR
//               flash. spi_clk/spi_cs/spi_di are oversampled in the sclk
//               domain. Opcodes are decoded, spi_do is driven, and WEL/WIP are
//               modelled with a timed chip erase.
//               Optional macro SPI_FLASH_RESPONDER_JEDEC_EN enables the 9Fh
//               JEDEC ID response. Without it, 9Fh is sunk and reads FFh.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module spi_flash_responder #(
    parameter int          ERASE_CYCLES = 2000,
    parameter logic [7:0]  MFR_ID       = 8'hEF,
    parameter logic [15:0] DEV_ID       = 16'h4017
) (
    input  logic       sclk,
    input  logic       rst,
    input  logic       spi_clk,
    input  logic       spi_cs,
    input  logic       spi_di,
    output logic       spi_do,
    output logic [7:0] status,
    output logic       erase_done,
    output logic       cmd_valid,
    output logic [7:0] cmd_byte
);

    localparam int                c_cnt_w      = $clog2(ERASE_CYCLES + 1);
    localparam logic [c_cnt_w-1:0] c_erase_load = c_cnt_w'(ERASE_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMD  = 2'd1,
        ST_RESP = 2'd2,
        ST_SINK = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [2:0]         cs_sync_q, cs_sync_d;
    logic [2:0]         clk_sync_q, clk_sync_d;
    logic [1:0]         di_sync_q, di_sync_d;
    logic [3:0]         bit_cnt_q, bit_cnt_d;
    logic [6:0]         shift_q, shift_d;
    logic [7:0]         tx_q, tx_d;
    logic [2:0]         tx_cnt_q, tx_cnt_d;
    logic               spi_do_q, spi_do_d;
    logic               wel_q, wel_d;
    logic               wip_q, wip_d;
    logic [c_cnt_w-1:0] erase_cnt_q, erase_cnt_d;
    logic               erase_done_q, erase_done_d;
    logic               cmd_valid_q, cmd_valid_d;
    logic [7:0]         cmd_byte_q, cmd_byte_d;

    logic               w_cs_rise, w_cs_fall, w_clk_rise, w_clk_fall;
    logic [7:0]         w_rx_byte, w_status, w_first_byte, w_next_byte;
    logic               w_is_resp;

    // Edge detection on the 2nd/3rd synchronizer stages
    assign w_cs_rise  =  cs_sync_q[1] & ~cs_sync_q[2];
    assign w_cs_fall  = ~cs_sync_q[1] &  cs_sync_q[2];
    assign w_clk_rise =  clk_sync_q[1] & ~clk_sync_q[2];
    assign w_clk_fall = ~clk_sync_q[1] &  clk_sync_q[2];
    assign w_rx_byte  = {shift_q, di_sync_q[1]};
    assign w_status   = {6'b0, wel_q, wip_q};

`ifdef SPI_FLASH_RESPONDER_JEDEC_EN
    logic       resp_id_q, resp_id_d;
    logic [1:0] byte_idx_q, byte_idx_d;
    logic [7:0] w_id_byte;

    // Select the ID byte for the current position in the 9Fh response
    always_comb begin
        w_id_byte = 8'h00;
        case (byte_idx_q)
            2'd0:    w_id_byte = MFR_ID;
            2'd1:    w_id_byte = DEV_ID[15:8];
            2'd2:    w_id_byte = DEV_ID[7:0];
            default: w_id_byte = 8'h00;
        endcase
    end

    assign w_is_resp    = (w_rx_byte == 8'h05) || (w_rx_byte == 8'h9F);
    assign w_first_byte = (w_rx_byte == 8'h9F) ? MFR_ID : w_status;
    assign w_next_byte  = resp_id_q ? w_id_byte : w_status;
`else
    logic w_unused_id;
    assign w_unused_id  = ^{MFR_ID, DEV_ID};
    assign w_is_resp    = (w_rx_byte == 8'h05);
    assign w_first_byte = w_status;
    assign w_next_byte  = w_status;
`endif

    // Next-state logic: synchronizers, erase timer, frame FSM and commits
    always_comb begin
        cs_sync_d    = {cs_sync_q[1:0], spi_cs};
        clk_sync_d   = {clk_sync_q[1:0], spi_clk};
        di_sync_d    = {di_sync_q[0], spi_di};
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        tx_d         = tx_q;
        tx_cnt_d     = tx_cnt_q;
        spi_do_d     = spi_do_q;
        wel_d        = wel_q;
        wip_d        = wip_q;
        erase_cnt_d  = erase_cnt_q;
        erase_done_d = 1'b0;
        cmd_valid_d  = 1'b0;
        cmd_byte_d   = cmd_byte_q;
`ifdef SPI_FLASH_RESPONDER_JEDEC_EN
        resp_id_d    = resp_id_q;
        byte_idx_d   = byte_idx_q;
`endif

        // Erase timer; completion clears both WIP and WEL
        if (wip_q) begin
            if (erase_cnt_q <= c_cnt_w'(1)) begin
                erase_cnt_d  = '0;
                wip_d        = 1'b0;
                wel_d        = 1'b0;
                erase_done_d = 1'b1;
            end else begin
                erase_cnt_d = erase_cnt_q - c_cnt_w'(1);
            end
        end

        if (cs_sync_q[1]) begin
            // Deselected: force idle. A cs rise commits only a clean 8-bit
            // frame, and never while busy (this also drops a frame whose
            // cs rise coincides with erase completion).
            state_d   = ST_IDLE;
            bit_cnt_d = 4'd0;
            spi_do_d  = 1'b1;
            if (w_cs_rise && !wip_q && (bit_cnt_q == 4'd8) &&
                ((state_q == ST_RESP) || (state_q == ST_SINK))) begin
                case (cmd_byte_q)
                    8'h06: wel_d = 1'b1;
                    8'h04: wel_d = 1'b0;
                    8'hC7, 8'h60: begin
                        if (wel_q) begin
                            wip_d       = 1'b1;
                            erase_cnt_d = c_erase_load;
                        end
                    end
                    default: ;
                endcase
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (w_cs_fall) begin
                        state_d   = ST_CMD;
                        bit_cnt_d = 4'd0;
                    end
                end
                ST_CMD: begin
                    if (w_clk_rise) begin
                        shift_d   = w_rx_byte[6:0];
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (bit_cnt_q == 4'd7) begin
                            cmd_byte_d  = w_rx_byte;
                            cmd_valid_d = 1'b1;
                            if (w_is_resp) begin
                                state_d  = ST_RESP;
                                tx_d     = w_first_byte;
                                tx_cnt_d = 3'd0;
`ifdef SPI_FLASH_RESPONDER_JEDEC_EN
                                resp_id_d  = (w_rx_byte == 8'h9F);
                                byte_idx_d = 2'd1;
`endif
                            end else begin
                                state_d = ST_SINK;
                            end
                        end
                    end
                end
                ST_RESP: begin
                    if (w_clk_rise && (bit_cnt_q != 4'd9)) begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                    if (w_clk_fall) begin
                        spi_do_d = tx_q[7];
                        tx_cnt_d = tx_cnt_q + 3'd1;
                        if (tx_cnt_q == 3'd7) begin
                            tx_d = w_next_byte;
`ifdef SPI_FLASH_RESPONDER_JEDEC_EN
                            if (byte_idx_q != 2'd3) begin
                                byte_idx_d = byte_idx_q + 2'd1;
                            end
`endif
                        end else begin
                            tx_d = {tx_q[6:0], 1'b0};
                        end
                    end
                end
                default: begin
                    spi_do_d = 1'b1;
                    if (w_clk_rise && (bit_cnt_q != 4'd9)) begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end
            endcase
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge sclk) begin
        if (rst) begin
            cs_sync_q    <= 3'b111;
            clk_sync_q   <= 3'b000;
            di_sync_q    <= 2'b00;
            state_q      <= ST_IDLE;
            bit_cnt_q    <= 4'd0;
            shift_q      <= 7'd0;
            tx_q         <= 8'd0;
            tx_cnt_q     <= 3'd0;
            spi_do_q     <= 1'b1;
            wel_q        <= 1'b0;
            wip_q        <= 1'b0;
            erase_cnt_q  <= '0;
            erase_done_q <= 1'b0;
            cmd_valid_q  <= 1'b0;
            cmd_byte_q   <= 8'd0;
`ifdef SPI_FLASH_RESPONDER_JEDEC_EN
            resp_id_q    <= 1'b0;
            byte_idx_q   <= 2'd0;
`endif
        end else begin
            cs_sync_q    <= cs_sync_d;
            clk_sync_q   <= clk_sync_d;
            di_sync_q    <= di_sync_d;
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            tx_q         <= tx_d;
            tx_cnt_q     <= tx_cnt_d;
            spi_do_q     <= spi_do_d;
            wel_q        <= wel_d;
            wip_q        <= wip_d;
            erase_cnt_q  <= erase_cnt_d;
            erase_done_q <= erase_done_d;
            cmd_valid_q  <= cmd_valid_d;
            cmd_byte_q   <= cmd_byte_d;
`ifdef SPI_FLASH_RESPONDER_JEDEC_EN
            resp_id_q    <= resp_id_d;
            byte_idx_q   <= byte_idx_d;
`endif
        end
    end

    assign spi_do     = spi_do_q;
    assign status     = w_status;
    assign erase_done = erase_done_q;
    assign cmd_valid  = cmd_valid_q;
    assign cmd_byte   = cmd_byte_q;

endmodule

`default_nettype wire

// File: tb/tb_spi_flash_responder.sv
//==============================================================================
// Module      : tb_spi_flash_responder
// Description : Directed self-checking bench for spi_flash_responder.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_spi_flash_responder;

    localparam int c_erase = 1000;

    logic       sclk = 1'b0;
    logic       rst = 1'b1;
    logic       spi_clk = 1'b0;
    logic       spi_cs = 1'b1;
    logic       spi_di = 1'b0;
    logic       spi_do;
    logic [7:0] status;
    logic       erase_done;
    logic       cmd_valid;
    logic [7:0] cmd_byte;

    int total = 0;
    int bad = 0;
    int n_cmd = 0;
    int n_done = 0;

    spi_flash_responder #(
        .ERASE_CYCLES(c_erase),
        .MFR_ID      (8'hEF),
        .DEV_ID      (16'h4017)
    ) u_dut (
        .sclk      (sclk),
        .rst       (rst),
        .spi_clk   (spi_clk),
        .spi_cs    (spi_cs),
        .spi_di    (spi_di),
        .spi_do    (spi_do),
        .status    (status),
        .erase_done(erase_done),
        .cmd_valid (cmd_valid),
        .cmd_byte  (cmd_byte)
    );

    always #5 sclk = ~sclk;

    // Pulse counters sampled mid-cycle
    always @(negedge sclk) begin
        if (cmd_valid === 1'b1) n_cmd = n_cmd + 1;
        if (erase_done === 1'b1) n_done = n_done + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total = total + 1;
        assert (obs === exp) else begin
            bad = bad + 1;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One SPI frame: nbits of opcode (extra bits are 0), then nread bytes read back
    task automatic spi_frame(input logic [7:0] op, input int nbits, input int nread,
                             output logic [31:0] rx);
        rx = '0;
        spi_cs = 1'b0;
        #100;
        for (int i = 0; i < nbits; i++) begin
            spi_di = (i < 8) ? op[7 - i] : 1'b0;
            #80 spi_clk = 1'b1;
            #80 spi_clk = 1'b0;
        end
        spi_di = 1'b0;
        for (int i = 0; i < 8 * nread; i++) begin
            #80 rx = {rx[30:0], spi_do};
            spi_clk = 1'b1;
            #80 spi_clk = 1'b0;
        end
        #80 spi_cs = 1'b1;
        #200;
    endtask

    logic [31:0] rx;
    int          cmd0;
    int          done0;
    logic        seen;

    initial begin
        // 1: reset state, then a status read
        rst = 1'b1;
        repeat (2) @(negedge sclk);
        check("rst_spi_do", {31'd0, spi_do}, 32'd1);
        check("rst_status", {24'd0, status}, 32'h00);
        check("rst_cmd_byte", {24'd0, cmd_byte}, 32'h00);
        check("rst_pulses", n_cmd + n_done, 0);
        rst = 1'b0;
        repeat (4) @(negedge sclk);
        spi_frame(8'h05, 8, 1, rx);
        check("rdsr_init", rx, 32'h00);
        check("rdsr_init_cmd", {24'd0, cmd_byte}, 32'h05);

        // 2: WREN then status read
        cmd0 = n_cmd;
        spi_frame(8'h06, 8, 0, rx);
        check("wren_cmd_byte", {24'd0, cmd_byte}, 32'h06);
        spi_frame(8'h05, 8, 1, rx);
        check("wren_rdsr", rx, 32'h02);
        check("wren_cmd_cnt", n_cmd - cmd0, 2);
        check("wren_last_cmd", {24'd0, cmd_byte}, 32'h05);

        // 3: chip erase, poll, WRDI ignored while busy, completion
        done0 = n_done;
        spi_frame(8'hC7, 8, 0, rx);
        check("ce_status", {24'd0, status}, 32'h03);
        spi_frame(8'h05, 8, 2, rx);
        check("ce_rdsr_x2", rx, 32'h0303);
        spi_frame(8'h04, 8, 0, rx);
        check("ce_wrdi_ignored", {24'd0, status}, 32'h03);
        seen = 1'b0;
        for (int i = 0; i < 3 * c_erase; i++) begin
            @(negedge sclk);
            if (n_done != done0) begin
                seen = 1'b1;
                break;
            end
        end
        check("ce_done_seen", {31'd0, seen}, 32'd1);
        repeat (5) @(negedge sclk);
        check("ce_done_once", n_done - done0, 1);
        check("ce_status_after", {24'd0, status}, 32'h00);
        spi_frame(8'h05, 8, 1, rx);
        check("ce_rdsr_after", rx, 32'h00);

        // 4: erase without WEL, short and long WREN frames
        done0 = n_done;
        spi_frame(8'h60, 8, 0, rx);
        check("ce_nowel_status", {24'd0, status}, 32'h00);
        repeat (c_erase + 100) @(negedge sclk);
        check("ce_nowel_done", n_done - done0, 0);
        cmd0 = n_cmd;
        spi_frame(8'h06, 5, 0, rx);
        check("wren5_status", {24'd0, status}, 32'h00);
        check("wren5_no_cmd", n_cmd - cmd0, 0);
        spi_frame(8'h06, 9, 0, rx);
        check("wren9_status", {24'd0, status}, 32'h00);

        // 5: JEDEC ID
        spi_frame(8'h9F, 8, 4, rx);
`ifdef SPI_FLASH_RESPONDER_JEDEC_EN
        check("jedec_id", rx, 32'hEF401700);
`else
        check("jedec_sink", rx, 32'hFFFFFFFF);
`endif

        // 6: reset mid-erase with cs toggled mid-byte
        spi_frame(8'h06, 8, 0, rx);
        spi_frame(8'hC7, 8, 0, rx);
        check("abort_busy", {24'd0, status}, 32'h03);
        repeat (100) @(negedge sclk);
        spi_cs = 1'b0;
        #100;
        for (int i = 0; i < 3; i++) begin
            spi_di = 1'b0;
            #80 spi_clk = 1'b1;
            #80 spi_clk = 1'b0;
        end
        @(negedge sclk);
        rst = 1'b1;
        spi_cs = 1'b1;
        cmd0 = n_cmd;
        done0 = n_done;
        repeat (2) @(negedge sclk);
        rst = 1'b0;
        repeat (4) @(negedge sclk);
        check("abort_spi_do", {31'd0, spi_do}, 32'd1);
        check("abort_status", {24'd0, status}, 32'h00);
        check("abort_cmd_byte", {24'd0, cmd_byte}, 32'h00);
        repeat (c_erase + 100) @(negedge sclk);
        check("abort_no_pulses", (n_cmd - cmd0) + (n_done - done0), 0);
        spi_frame(8'h05, 8, 1, rx);
        check("abort_rdsr", rx, 32'h00);
        spi_frame(8'h06, 8, 0, rx);
        spi_frame(8'h05, 8, 1, rx);
        check("abort_wren_rdsr", rx, 32'h02);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
